// File: rtl/clock_divider_bank.sv
`default_nettype none
// ============================================================================
//  Module   : clock_divider_bank
//  Purpose  : Bank of independent programmable clock dividers. Each channel
//             divides clock by (div_act+1) and drives either a 50 % square
//             wave (toggle mode) or a one-cycle strobe (pulse mode).
//             Divisor/mode writes land in a shadow register. The shadow is
//             copied to the active register only at an apply event: terminal
//             count, sync, or the channel being disabled. This keeps outputs
//             glitch-free.
//  Ports    : clock        - system clock, rising edge
//             reset_n      - asynchronous active-low reset
//             en           - per-channel run enable (level)
//             sync         - restart all enabled channels in phase
//             cfg_we       - configuration write strobe
//             cfg_chan     - target channel (values >= CHANNELS ignored)
//             cfg_div      - new divisor
//             cfg_mode     - new mode: 0 toggle, 1 pulse
//             out          - divided output per channel (registered)
//             tick         - terminal-count strobe per channel (registered)
//             cfg_pending  - shadow holds a value not yet applied
//  Revision : 1.0 - initial release
// ============================================================================
module clock_divider_bank #(
    parameter  int CHANNELS    = 2,
    parameter  int WIDTH       = 25,
    parameter  int DEFAULT_DIV = 25000,
    localparam int c_CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                cfg_we,
    input  logic [c_CW-1:0]     cfg_chan,
    input  logic [WIDTH-1:0]    cfg_div,
    input  logic                cfg_mode,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] cfg_pending
);

    localparam logic [WIDTH-1:0] c_DEF_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] c_ONE     = WIDTH'(1);

    // Parameter sanity checks, reported at elaboration time.
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("clock_divider_bank: CHANNELS must be 1..16");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("clock_divider_bank: WIDTH must be at least 1");
    end
    if (DEFAULT_DIV < 0 || (WIDTH < 31 && (DEFAULT_DIV >> WIDTH) != 0)) begin : g_bad_default
        $error("clock_divider_bank: DEFAULT_DIV does not fit in WIDTH bits");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [WIDTH-1:0] r_cnt_q,     w_cnt_d;
        logic [WIDTH-1:0] r_div_act_q, w_div_act_d;
        logic [WIDTH-1:0] r_div_shd_q, w_div_shd_d;
        logic             r_mode_act_q, w_mode_act_d;
        logic             r_mode_shd_q, w_mode_shd_d;
        logic             r_pend_q,    w_pend_d;
        logic             r_out_q,     w_out_d;
        logic             r_tick_q,    w_tick_d;
        logic             w_tc;
        logic             w_apply;
        logic             w_wr;

        always_comb begin
            w_tc    = en[i] && (r_cnt_q == r_div_act_q);
            // Any event that restarts the count is a safe point to switch
            // divisor/mode; the shadow moves over only if one is waiting.
            w_apply = r_pend_q && (!en[i] || sync || w_tc);
            // Channel index compare also rejects out-of-range cfg_chan.
            w_wr    = cfg_we && (int'(cfg_chan) == i);

            w_cnt_d  = r_cnt_q;
            w_out_d  = r_out_q;
            w_tick_d = 1'b0;

            if (!en[i] || sync) begin
                w_cnt_d = '0;
                w_out_d = 1'b0;
            end else if (w_tc) begin
                w_cnt_d  = '0;
                w_tick_d = 1'b1;
                // Uses the mode in force before any apply on this edge.
                w_out_d  = r_mode_act_q ? 1'b1 : ~r_out_q;
            end else begin
                w_cnt_d = r_cnt_q + c_ONE;
                if (r_mode_act_q) begin
                    w_out_d = 1'b0;
                end
            end

            w_div_act_d  = w_apply ? r_div_shd_q  : r_div_act_q;
            w_mode_act_d = w_apply ? r_mode_shd_q : r_mode_act_q;

            // A write coinciding with an apply lands in the shadow and stays
            // pending; the apply on that edge uses the previous shadow.
            w_div_shd_d  = w_wr ? cfg_div  : r_div_shd_q;
            w_mode_shd_d = w_wr ? cfg_mode : r_mode_shd_q;
            if (w_wr) begin
                w_pend_d = 1'b1;
            end else if (w_apply) begin
                w_pend_d = 1'b0;
            end else begin
                w_pend_d = r_pend_q;
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt_q      <= '0;
                r_div_act_q  <= c_DEF_DIV;
                r_div_shd_q  <= c_DEF_DIV;
                r_mode_act_q <= 1'b0;
                r_mode_shd_q <= 1'b0;
                r_pend_q     <= 1'b0;
                r_out_q      <= 1'b0;
                r_tick_q     <= 1'b0;
            end else begin
                r_cnt_q      <= w_cnt_d;
                r_div_act_q  <= w_div_act_d;
                r_div_shd_q  <= w_div_shd_d;
                r_mode_act_q <= w_mode_act_d;
                r_mode_shd_q <= w_mode_shd_d;
                r_pend_q     <= w_pend_d;
                r_out_q      <= w_out_d;
                r_tick_q     <= w_tick_d;
            end
        end

        assign out[i]         = r_out_q;
        assign tick[i]        = r_tick_q;
        assign cfg_pending[i] = r_pend_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_clock_divider_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_divider_bank
//  Purpose  : Directed self-checking bench for clock_divider_bank with
//             CHANNELS=3 (so cfg_chan=3 is out of range), WIDTH=8,
//             DEFAULT_DIV=3. Expected values are hand-derived per edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clock_divider_bank;

    logic       clock;
    logic       reset_n;
    logic [2:0] en;
    logic       sync;
    logic       cfg_we;
    logic [1:0] cfg_chan;
    logic [7:0] cfg_div;
    logic       cfg_mode;
    logic [2:0] out;
    logic [2:0] tick;
    logic [2:0] cfg_pending;

    int n_assert = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    clock_divider_bank #(
        .CHANNELS    (3),
        .WIDTH       (8),
        .DEFAULT_DIV (3)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .en          (en),
        .sync        (sync),
        .cfg_we      (cfg_we),
        .cfg_chan    (cfg_chan),
        .cfg_div     (cfg_div),
        .cfg_mode    (cfg_mode),
        .out         (out),
        .tick        (tick),
        .cfg_pending (cfg_pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
        edge_n++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s (edge %0d): observed %0h expected %0h", tag, edge_n, obs, exp);
        end
    endtask

    initial begin
        logic e;
        logic t;
        logic p;

        reset_n = 1'b0; en = 3'b000; sync = 1'b0;
        cfg_we = 1'b0; cfg_chan = 2'd0; cfg_div = 8'd0; cfg_mode = 1'b0;

        // Reset state
        step(); step();
        chk("rst_out", out, 0);
        chk("rst_tick", tick, 0);
        chk("rst_pend", cfg_pending, 0);
        en = 3'b011;
        step();
        chk("rst_out_en", out, 0);
        chk("rst_tick_en", tick, 0);

        // Reset release: div 3 toggle -> tick every 4, out period 8
        reset_n = 1'b1;
        edge_n  = 0;
        repeat (16) begin
            step();
            e = ((edge_n / 4) % 2) == 1;
            t = (edge_n % 4) == 0;
            chk("t1_out", out, {1'b0, e, e});
            chk("t1_tick", tick, {1'b0, t, t});
        end

        // Write ch1 div=1 pulse mid-period; applies at tc of edge 20
        cfg_we = 1'b1; cfg_chan = 2'd1; cfg_div = 8'd1; cfg_mode = 1'b1;
        step();
        cfg_we = 1'b0;
        chk("t2_pend17", cfg_pending, 3'b010);
        step();
        chk("t2_pend18", cfg_pending, 3'b010);
        step();
        chk("t2_pend19", cfg_pending, 3'b010);
        chk("t2_tick19", tick, 3'b000);
        step();
        chk("t2_pend20", cfg_pending, 3'b000);
        chk("t2_tick20", tick, 3'b011);
        chk("t2_out20", out, 3'b011);
        while (edge_n < 28) begin
            step();
            e = ((edge_n / 4) % 2) == 1;
            t = (edge_n % 4) == 0;
            p = (edge_n % 2) == 0;
            chk("t2_out", out, {1'b0, p, e});
            chk("t2_tick", tick, {1'b0, p, t});
        end

        // Two writes to ch0 before its tc: last (div=2) wins, applied at 32
        cfg_we = 1'b1; cfg_chan = 2'd0; cfg_div = 8'd5; cfg_mode = 1'b0;
        step();
        cfg_div = 8'd2;
        step();
        cfg_we = 1'b0;
        chk("t3_pend30", cfg_pending, 3'b001);
        step(); step();
        chk("t3_pend32", cfg_pending, 3'b000);
        chk("t3_tick32", tick[0], 1);
        while (edge_n < 40) begin
            step();
            chk("t3_tick0", tick[0], (edge_n == 35) || (edge_n == 38));
        end
        // Write coincident with tc at edge 41: stays pending until tc at 44
        cfg_we = 1'b1; cfg_chan = 2'd0; cfg_div = 8'd4; cfg_mode = 1'b0;
        step();
        cfg_we = 1'b0;
        chk("t3_tick41", tick[0], 1);
        chk("t3_pend41", cfg_pending[0], 1);
        while (edge_n < 54) begin
            step();
            chk("t3_tick0_d4", tick[0], (edge_n == 44) || (edge_n == 49) || (edge_n == 54));
            chk("t3_pend0", cfg_pending[0], edge_n < 44);
            chk("t3_out1", out[1], (edge_n % 2) == 0);
        end

        // div=0 toggle on ch0: applied at tc 59, then out toggles each clock
        cfg_we = 1'b1; cfg_chan = 2'd0; cfg_div = 8'd0; cfg_mode = 1'b0;
        step();
        cfg_we = 1'b0;
        while (edge_n < 59) step();
        chk("t4_pend59", cfg_pending[0], 0);
        chk("t4_tick59", tick[0], 1);
        while (edge_n < 65) begin
            step();
            chk("t4_tick0", tick[0], 1);
            chk("t4_out0", out[0], (edge_n % 2) == 1);
        end
        // Pending write (div 3 pulse), then disable: shadow applies at once
        cfg_we = 1'b1; cfg_chan = 2'd0; cfg_div = 8'd3; cfg_mode = 1'b1;
        step();
        cfg_we = 1'b0;
        en[0]  = 1'b0;
        chk("t4_pend66", cfg_pending[0], 1);
        step();
        chk("t4_dis_out", out[0], 0);
        chk("t4_dis_tick", tick[0], 0);
        chk("t4_dis_pend", cfg_pending[0], 0);
        step();
        en[0] = 1'b1;
        while (edge_n < 76) begin
            step();
            p = (edge_n == 72) || (edge_n == 76);
            chk("t4_en_tick0", tick[0], p);
            chk("t4_en_out0", out[0], p);
        end

        // ch1 -> div 5 toggle (applies at tc 78), then sync at edge 82
        cfg_we = 1'b1; cfg_chan = 2'd1; cfg_div = 8'd5; cfg_mode = 1'b0;
        step();
        cfg_we = 1'b0;
        step();
        chk("t5_pend78", cfg_pending, 3'b000);
        chk("t5_out1_78", out[1], 1);
        step(); step(); step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        chk("t5_sync_out", out, 3'b000);
        chk("t5_sync_tick", tick, 3'b000);
        while (edge_n < 88) begin
            step();
            chk("t5_tick", tick, {1'b0, edge_n == 88, edge_n == 86});
            chk("t5_out", out, {1'b0, edge_n == 88, edge_n == 86});
        end

        // Reset mid-count with a write pending
        cfg_we = 1'b1; cfg_chan = 2'd1; cfg_div = 8'd7; cfg_mode = 1'b1;
        step();
        cfg_we = 1'b0;
        chk("t6_pend89", cfg_pending, 3'b010);
        step();
        chk("t6_out90", out, 3'b011);
        chk("t6_tick90", tick, 3'b001);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_arst_out", out, 0);
        chk("t6_arst_tick", tick, 0);
        chk("t6_arst_pend", cfg_pending, 0);
        #1 reset_n = 1'b1;
        edge_n = 0;
        // Out-of-range channel write must not change anything
        cfg_we = 1'b1; cfg_chan = 2'd3; cfg_div = 8'd1; cfg_mode = 1'b1;
        repeat (8) begin
            step();
            if (edge_n == 1) begin
                cfg_we = 1'b0;
                chk("t6_bad_chan_pend", cfg_pending, 3'b000);
            end
            e = ((edge_n / 4) % 2) == 1;
            t = (edge_n % 4) == 0;
            chk("t6_out", out, {1'b0, e, e});
            chk("t6_tick", tick, {1'b0, t, t});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
